// File: rtl/stack_if.sv
// Handshake/data bundle between a stack client (master) and stack_ctrl (slave).
interface stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, clear, data_in,
    input  data_out, data_valid, top, count, empty, full, almost_full,
           overflow, underflow
  );

  modport slave (
    input  push, pop, clear, data_in,
    output data_out, data_valid, top, count, empty, full, almost_full,
           overflow, underflow
  );
endinterface

// File: rtl/stack_ctrl.sv
// DEPTH-entry LIFO with occupancy count, almost-full threshold, replace-top,
// empty bypass, synchronous flush, combinational peek and sticky error flags.
module stack_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic    clk,
  input  logic    rst,
  stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  // Index width: only needs to address entries 0..DEPTH-1.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_almost_full;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_top;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CW'(DEPTH));
  assign w_almost_full = (r_count >= CW'(AF_LEVEL));

  // count-1 is only meaningful when not empty; the peek is gated below.
  assign w_top_idx = AW'(r_count - CW'(1));
  assign w_top     = w_empty ? '0 : r_mem[w_top_idx];

  // A write lands either in the next free slot (push only, room left) or on
  // top of the current top entry (replace-top). Bypass never touches storage.
  assign w_wr_en  = bus.push && !bus.clear &&
                    (bus.pop ? !w_empty : !w_full);
  assign w_wr_idx = bus.pop ? w_top_idx : AW'(r_count);

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[w_wr_idx] <= bus.data_in;
    end
  end

  // Occupancy, popped-word register and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (bus.clear) begin
        r_count     <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        case ({bus.push, bus.pop})
          2'b10: begin
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
          2'b01: begin
            if (w_empty) begin
              r_underflow <= 1'b1;
            end else begin
              r_data_out   <= w_top;
              r_data_valid <= 1'b1;
              r_count      <= r_count - CW'(1);
            end
          end
          2'b11: begin
            // Replace-top returns the old top; on empty the word passes through.
            r_data_out   <= w_empty ? bus.data_in : w_top;
            r_data_valid <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.data_valid  = r_data_valid;
  assign bus.top         = w_top;
  assign bus.count       = r_count;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = w_almost_full;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: DEPTH=4/AF=3 and DEPTH=5/AF=5 instances.
module tb_stack_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stack_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  stack_if #(.WIDTH(8), .DEPTH(5)) bus5 ();

  stack_ctrl #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  stack_ctrl #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(5)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle4;
    bus4.push = 0; bus4.pop = 0; bus4.clear = 0; bus4.data_in = 8'h00;
  endtask

  task automatic idle5;
    bus5.push = 0; bus5.pop = 0; bus5.clear = 0; bus5.data_in = 8'h00;
  endtask

  task automatic test_reset;
    idle4(); idle5();
    rst = 1; tick(); rst = 0;
    $display("reset applied");
    checks++; if (bus4.count !== 3'd0) begin failures++; $display("FAIL reset_count act=%0d exp=0", bus4.count); end
    checks++; if (bus4.empty !== 1'b1) begin failures++; $display("FAIL reset_empty act=%b exp=1", bus4.empty); end
    checks++; if (bus4.data_out !== 8'h00) begin failures++; $display("FAIL reset_dout act=%h exp=00", bus4.data_out); end
    checks++; if (bus4.data_valid !== 1'b0) begin failures++; $display("FAIL reset_dv act=%b exp=0", bus4.data_valid); end
    checks++; if ({bus4.overflow, bus4.underflow, bus4.full, bus4.almost_full} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags act=%b exp=0000", {bus4.overflow, bus4.underflow, bus4.full, bus4.almost_full}); end
    checks++; if (bus4.top !== 8'h00) begin failures++; $display("FAIL reset_top act=%h exp=00", bus4.top); end
  endtask

  task automatic test_fill;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      bus4.push = 1; bus4.data_in = vals[i]; tick();
      $display("push %h -> count=%0d af=%b full=%b top=%h", vals[i], bus4.count, bus4.almost_full, bus4.full, bus4.top);
      checks++; if (bus4.count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count act=%0d exp=%0d", bus4.count, i + 1); end
      checks++; if (bus4.almost_full !== ((i + 1) >= 3)) begin failures++; $display("FAIL fill_af act=%b exp=%b", bus4.almost_full, (i + 1) >= 3); end
      checks++; if (bus4.full !== ((i + 1) == 4)) begin failures++; $display("FAIL fill_full act=%b exp=%b", bus4.full, (i + 1) == 4); end
      checks++; if (bus4.top !== vals[i]) begin failures++; $display("FAIL fill_top act=%h exp=%h", bus4.top, vals[i]); end
    end
    idle4();
    checks++; if (bus4.overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf act=%b exp=0", bus4.overflow); end
  endtask

  task automatic test_overflow_pop;
    logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    bus4.push = 1; bus4.data_in = 8'h55; tick(); idle4();
    $display("push 55 at full -> count=%0d ovf=%b", bus4.count, bus4.overflow);
    checks++; if (bus4.count !== 3'd4) begin failures++; $display("FAIL ovf_count act=%0d exp=4", bus4.count); end
    checks++; if (bus4.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag act=%b exp=1", bus4.overflow); end
    checks++; if (bus4.top !== 8'h44) begin failures++; $display("FAIL ovf_top act=%h exp=44", bus4.top); end
    for (int i = 0; i < 4; i++) begin
      bus4.pop = 1; tick(); idle4();
      $display("pop -> dout=%h dv=%b count=%0d", bus4.data_out, bus4.data_valid, bus4.count);
      checks++; if (bus4.data_valid !== 1'b1) begin failures++; $display("FAIL pop_dv act=%b exp=1", bus4.data_valid); end
      checks++; if (bus4.data_out !== exp[i]) begin failures++; $display("FAIL pop_dout act=%h exp=%h", bus4.data_out, exp[i]); end
      tick();
      checks++; if (bus4.data_valid !== 1'b0) begin failures++; $display("FAIL pop_dv_pulse act=%b exp=0", bus4.data_valid); end
    end
    checks++; if (bus4.empty !== 1'b1) begin failures++; $display("FAIL pop_empty act=%b exp=1", bus4.empty); end
  endtask

  task automatic test_underflow_clear;
    bus4.pop = 1; tick(); idle4();
    $display("pop at empty -> udf=%b dv=%b dout=%h", bus4.underflow, bus4.data_valid, bus4.data_out);
    checks++; if (bus4.underflow !== 1'b1) begin failures++; $display("FAIL udf_flag act=%b exp=1", bus4.underflow); end
    checks++; if (bus4.data_valid !== 1'b0) begin failures++; $display("FAIL udf_dv act=%b exp=0", bus4.data_valid); end
    checks++; if (bus4.data_out !== 8'h11) begin failures++; $display("FAIL udf_dout act=%h exp=11", bus4.data_out); end
    checks++; if (bus4.count !== 3'd0) begin failures++; $display("FAIL udf_count act=%0d exp=0", bus4.count); end
    bus4.clear = 1; tick(); idle4();
    $display("clear -> udf=%b ovf=%b count=%0d", bus4.underflow, bus4.overflow, bus4.count);
    checks++; if ({bus4.underflow, bus4.overflow} !== 2'b00) begin failures++; $display("FAIL clr_flags act=%b exp=00", {bus4.underflow, bus4.overflow}); end
    checks++; if (bus4.data_out !== 8'h11) begin failures++; $display("FAIL clr_dout act=%h exp=11", bus4.data_out); end
  endtask

  task automatic test_replace;
    logic [7:0] exp [4] = '{8'hD0, 8'h01, 8'hC0, 8'hA0};
    bus4.push = 1; bus4.data_in = 8'hA0; tick();
    bus4.data_in = 8'hB0; tick();
    bus4.pop = 1; bus4.data_in = 8'hC0; tick(); idle4();
    $display("push+pop C0 -> dout=%h dv=%b count=%0d top=%h", bus4.data_out, bus4.data_valid, bus4.count, bus4.top);
    checks++; if (bus4.data_out !== 8'hB0) begin failures++; $display("FAIL rep_dout act=%h exp=b0", bus4.data_out); end
    checks++; if (bus4.data_valid !== 1'b1) begin failures++; $display("FAIL rep_dv act=%b exp=1", bus4.data_valid); end
    checks++; if (bus4.count !== 3'd2) begin failures++; $display("FAIL rep_count act=%0d exp=2", bus4.count); end
    checks++; if (bus4.top !== 8'hC0) begin failures++; $display("FAIL rep_top act=%h exp=c0", bus4.top); end
    bus4.push = 1; bus4.data_in = 8'h01; tick();
    bus4.data_in = 8'h02; tick();
    bus4.pop = 1; bus4.data_in = 8'hD0; tick(); idle4();
    $display("push+pop D0 at full -> dout=%h count=%0d ovf=%b", bus4.data_out, bus4.count, bus4.overflow);
    checks++; if (bus4.data_out !== 8'h02) begin failures++; $display("FAIL repf_dout act=%h exp=02", bus4.data_out); end
    checks++; if (bus4.count !== 3'd4) begin failures++; $display("FAIL repf_count act=%0d exp=4", bus4.count); end
    checks++; if (bus4.overflow !== 1'b0) begin failures++; $display("FAIL repf_ovf act=%b exp=0", bus4.overflow); end
    checks++; if (bus4.top !== 8'hD0) begin failures++; $display("FAIL repf_top act=%h exp=d0", bus4.top); end
    for (int i = 0; i < 4; i++) begin
      bus4.pop = 1; tick(); idle4();
      $display("drain pop -> dout=%h", bus4.data_out);
      checks++; if (bus4.data_out !== exp[i]) begin failures++; $display("FAIL rep_drain act=%h exp=%h", bus4.data_out, exp[i]); end
    end
  endtask

  task automatic test_bypass;
    bus4.push = 1; bus4.pop = 1; bus4.data_in = 8'h5A; tick(); idle4();
    $display("push+pop 5A at empty -> dout=%h dv=%b count=%0d", bus4.data_out, bus4.data_valid, bus4.count);
    checks++; if (bus4.data_out !== 8'h5A) begin failures++; $display("FAIL byp_dout act=%h exp=5a", bus4.data_out); end
    checks++; if (bus4.data_valid !== 1'b1) begin failures++; $display("FAIL byp_dv act=%b exp=1", bus4.data_valid); end
    checks++; if (bus4.count !== 3'd0) begin failures++; $display("FAIL byp_count act=%0d exp=0", bus4.count); end
    checks++; if (bus4.empty !== 1'b1) begin failures++; $display("FAIL byp_empty act=%b exp=1", bus4.empty); end
    checks++; if ({bus4.overflow, bus4.underflow} !== 2'b00) begin failures++; $display("FAIL byp_flags act=%b exp=00", {bus4.overflow, bus4.underflow}); end
  endtask

  task automatic test_rst_clear_priority;
    bus4.push = 1;
    for (int i = 1; i <= 3; i++) begin bus4.data_in = 8'(i); tick(); end
    rst = 1; bus4.data_in = 8'h77; tick(); rst = 0; idle4();
    $display("rst+push -> count=%0d dout=%h", bus4.count, bus4.data_out);
    checks++; if (bus4.count !== 3'd0) begin failures++; $display("FAIL rstp_count act=%0d exp=0", bus4.count); end
    checks++; if (bus4.data_out !== 8'h00) begin failures++; $display("FAIL rstp_dout act=%h exp=00", bus4.data_out); end
    checks++; if ({bus4.overflow, bus4.underflow, bus4.data_valid} !== 3'b000) begin
      failures++; $display("FAIL rstp_flags act=%b exp=000", {bus4.overflow, bus4.underflow, bus4.data_valid}); end
    bus4.push = 1;
    for (int i = 1; i <= 3; i++) begin bus4.data_in = 8'(i + 8'h30); tick(); end
    idle4(); bus4.pop = 1; tick(); idle4();
    checks++; if (bus4.data_out !== 8'h33) begin failures++; $display("FAIL clrp_pre act=%h exp=33", bus4.data_out); end
    bus4.clear = 1; bus4.pop = 1; tick(); idle4();
    $display("clear+pop -> count=%0d udf=%b dv=%b dout=%h", bus4.count, bus4.underflow, bus4.data_valid, bus4.data_out);
    checks++; if (bus4.count !== 3'd0) begin failures++; $display("FAIL clrp_count act=%0d exp=0", bus4.count); end
    checks++; if (bus4.underflow !== 1'b0) begin failures++; $display("FAIL clrp_udf act=%b exp=0", bus4.underflow); end
    checks++; if (bus4.data_valid !== 1'b0) begin failures++; $display("FAIL clrp_dv act=%b exp=0", bus4.data_valid); end
    checks++; if (bus4.data_out !== 8'h33) begin failures++; $display("FAIL clrp_dout act=%h exp=33", bus4.data_out); end
    bus4.pop = 1; tick(); idle4();
    $display("pop after clear -> udf=%b", bus4.underflow);
    checks++; if (bus4.underflow !== 1'b1) begin failures++; $display("FAIL clrp_next_udf act=%b exp=1", bus4.underflow); end
  endtask

  task automatic test_depth5;
    logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      bus5.push = 1; bus5.data_in = vals[i]; tick();
      $display("d5 push %h -> count=%0d af=%b full=%b", vals[i], bus5.count, bus5.almost_full, bus5.full);
      checks++; if (bus5.count !== 3'(i + 1)) begin failures++; $display("FAIL d5_count act=%0d exp=%0d", bus5.count, i + 1); end
      checks++; if (bus5.full !== ((i + 1) == 5)) begin failures++; $display("FAIL d5_full act=%b exp=%b", bus5.full, (i + 1) == 5); end
      checks++; if (bus5.almost_full !== ((i + 1) >= 5)) begin failures++; $display("FAIL d5_af act=%b exp=%b", bus5.almost_full, (i + 1) >= 5); end
    end
    bus5.data_in = 8'h66; tick(); idle5();
    $display("d5 push 66 at full -> count=%0d ovf=%b top=%h", bus5.count, bus5.overflow, bus5.top);
    checks++; if (bus5.count !== 3'd5) begin failures++; $display("FAIL d5_ovf_count act=%0d exp=5", bus5.count); end
    checks++; if (bus5.overflow !== 1'b1) begin failures++; $display("FAIL d5_ovf act=%b exp=1", bus5.overflow); end
    checks++; if (bus5.top !== 8'h55) begin failures++; $display("FAIL d5_top act=%h exp=55", bus5.top); end
    for (int i = 4; i >= 0; i--) begin
      bus5.pop = 1; tick(); idle5();
      $display("d5 pop -> dout=%h dv=%b", bus5.data_out, bus5.data_valid);
      checks++; if (bus5.data_out !== vals[i]) begin failures++; $display("FAIL d5_pop act=%h exp=%h", bus5.data_out, vals[i]); end
      checks++; if (bus5.data_valid !== 1'b1) begin failures++; $display("FAIL d5_dv act=%b exp=1", bus5.data_valid); end
    end
    checks++; if (bus5.empty !== 1'b1) begin failures++; $display("FAIL d5_empty act=%b exp=1", bus5.empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_pop();
    test_underflow_clear();
    test_replace();
    test_bypass();
    test_rst_clear_priority();
    test_depth5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Parameterised LIFO buffer that extends the basic push/pop stack. It adds a true DEPTH-entry capacity and an occupancy count, plus an almost-full threshold. It also supports simultaneous push+pop (replace-top, with bypass when empty), a synchronous flush, a combinational top-of-stack peek, and sticky overflow/underflow error flags. It is used as a general scratch stack for datapath and control blocks in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2); full means exactly DEPTH entries held
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
CW (localparam), $clog2(DEPTH+1), count width; not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
push  in  1  write request; data_in captured on the same edge
pop  in  1  read request
clear  in  1  synchronous flush
data_in  in  WIDTH  word to push
data_out  out  WIDTH  registered popped word; holds until the next pop
data_valid  out  1  one-cycle pulse; data_out updated on this edge
top  out  WIDTH  combinational peek of the current top entry
count  out  CW  number of entries held (0..DEPTH)
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
overflow  out  1  sticky: a push was dropped because the stack was full
underflow  out  1  sticky: a pop was dropped because the stack was empty

Behaviour:
- Reset (rst=1 at edge) has highest priority.
  - count=0, data_out=0, data_valid=0, overflow=0, underflow=0.
  - Storage array is not reset.
- Flags: empty, full and almost_full are combinational from count. No flag bit-tricks; compare count against DEPTH and AF_LEVEL directly.
- top = mem[count-1] when !empty, else all zeros. It depends only on registered state, with no path from push/pop/data_in.
- data_valid defaults to 0 every cycle unless one of the cases below sets it.
- Priority is rst > clear > push/pop.
- clear=1: count<=0, overflow<=0, underflow<=0, data_valid<=0, data_out unchanged. Any push/pop in the same cycle is ignored and raises no flags.
- push only, !full: mem[count]<=data_in, count<=count+1.
- push only, full: write dropped, count unchanged, overflow<=1.
- pop only, !empty: data_out<=mem[count-1], count<=count-1, data_valid<=1. Latency is 1 cycle from the pop edge to data_out/data_valid.
- pop only, empty: ignored, data_out unchanged, data_valid<=0, underflow<=1.
- push+pop, !empty (including full): replace-top.
  - data_out<=old mem[count-1], mem[count-1]<=data_in, count unchanged, data_valid<=1.
  - No overflow is flagged, even when full.
- push+pop, empty: bypass.
  - data_out<=data_in, data_valid<=1, count stays 0, storage untouched, no flags.
- Sticky flags stay set until rst or clear; further errors keep them at 1.
- count never exceeds DEPTH and never wraps below 0.
- Reset or clear mid-sequence discards all contents. The next pop after either is treated as empty (underflow).
- Non-power-of-2 DEPTH must work; index arithmetic uses CW bits with no modulo wrap.

Test Plan (WIDTH=8, DEPTH=4, AF_LEVEL=3 unless noted):
1. Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full at count=3; full at 4; top=0x44; overflow=0.
2. From full, push 0x55 -> count stays 4, overflow=1, top=0x44. Then pop x4 -> data_out 0x44,0x33,0x22,0x11, each with a one-cycle data_valid pulse one cycle after its pop; empty=1 after the last pop.
3. Empty stack, pop -> underflow=1, data_valid=0, data_out holds the previous value (0x11). Then clear -> underflow=0, overflow=0, count=0.
4. Push 0xA0,0xB0, then push+pop with data_in=0xC0 -> data_out=0xB0, data_valid=1, count=2, top=0xC0. Repeat at full with data_in=0xD0 -> no overflow, count=4.
5. Empty stack, push+pop with data_in=0x5A -> next cycle data_out=0x5A, data_valid=1, count=0, empty=1, no flags set.
6. Push 3 entries, assert rst together with push=1 -> count=0, data_out=0, all flags 0, write ignored. Repeat using clear+pop -> count=0, no underflow, data_valid=0. Also rerun scenarios 1–2 with DEPTH=5, AF_LEVEL=5 -> full only at count=5.
